// File: rtl/int_root_pkg.sv
// Shared types and constants for the integer n-th root engine.
// The state encoding and the saturation ceiling are used by both the top and the multiplier.
package int_root_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        POW,
        CMP
    } state_t;

    localparam logic        READY  = 1'b1;
    localparam logic        BUSY   = 1'b0;
    localparam logic [16:0] SAT    = 17'h10000;
    localparam logic [15:0] ERR_N0 = 16'hFFFF;

endpackage

// File: rtl/sat_mul17.sv
// Combinational 17x17 multiplier that clamps to SAT.
// ovf flags any product that reached the ceiling.
module sat_mul17
    import int_root_pkg::*;
(
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] y,
    output logic        ovf
);

    logic [33:0] prod;

    assign prod = {17'd0, a} * {17'd0, b};
    assign ovf  = (prod >= {17'd0, SAT});
    assign y    = ovf ? SAT : prod[16:0];

endmodule

// File: rtl/int_root.sv
// Iterative floor(x^(1/n)) engine: binary search over an 8-bit result, with each
// candidate raised to the n-th power by a saturating square-and-multiply loop.
module int_root
    import int_root_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] inx,
    input  logic [7:0]  inn,
    output logic        ready,
    output logic [15:0] out
);

    state_t      state_q, state_d;
    logic [15:0] x_q;
    logic [7:0]  n_q;
    logic [7:0]  r_q;
    logic [2:0]  b_q;
    logic [16:0] a_q;
    logic [16:0] p_q;
    logic [7:0]  e_q;
    logic        sat_q;
    logic        special_q;
    logic [15:0] out_q;

    logic [7:0]  cand;
    logic [7:0]  r_next;
    logic        done;
    logic [16:0] mul_a;
    logic [16:0] mul_y;
    logic        mul_ovf;

    // One multiplier serves both the squaring (p*p) and accumulating (a*p) steps.
    assign mul_a = e_q[0] ? a_q : p_q;

    sat_mul17 u_mul (
        .a   (mul_a),
        .b   (p_q),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    assign cand   = r_q | (8'd1 << b_q);
    assign r_next = (!sat_q && (a_q <= {1'b0, x_q})) ? cand : r_q;
    assign done   = (state_q == CMP) && (special_q || (b_q == 3'd0));
    assign ready  = (state_q == IDLE) ? READY : BUSY;
    assign out    = out_q;

    always_comb begin
        // NOTE: the default before the case keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (inn < 8'd2) ? CMP : CAND;
            CAND: state_d = POW;
            POW:  if (e_q == 8'd0) state_d = CMP;
            CMP:  state_d = (special_q || (b_q == 3'd0)) ? IDLE : CAND;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (done) begin
                if (special_q) out_q <= (n_q == 8'd0) ? ERR_N0 : x_q;
                else           out_q <= {8'h00, r_next};
            end
        end
    end

    // NOTE: datapath registers carry no reset; the state register alone decides when they are meaningful.
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_q       <= inx;
                    n_q       <= inn;
                    r_q       <= '0;
                    b_q       <= 3'd7;
                    special_q <= (inn < 8'd2);
                end
            end
            CAND: begin
                a_q   <= 17'd1;
                p_q   <= {9'd0, cand};
                e_q   <= n_q;
                sat_q <= 1'b0;
            end
            POW: begin
                if (e_q != 8'd0) begin
                    if (e_q[0]) begin
                        a_q <= mul_y;
                        e_q <= e_q - 8'd1;
                    end else begin
                        p_q <= mul_y;
                        e_q <= e_q >> 1;
                    end
                    sat_q <= sat_q | mul_ovf;
                end
            end
            CMP: begin
                if (!special_q) begin
                    r_q <= r_next;
                    b_q <= b_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_root.sv
// Self-checking bench for int_root: a cycle model built from root arithmetic and the
// latency formula is compared every cycle, plus directed jobs with literal results.
module tb_int_root;

    logic        clk   = 1'b0;
    logic        nrst  = 1'b1;
    logic        start = 1'b0;
    logic [15:0] inx   = '0;
    logic [7:0]  inn   = '0;
    logic        ready;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    int_root dut (
        .clk   (clk),
        .nrst  (nrst),
        .start (start),
        .inx   (inx),
        .inn   (inn),
        .ready (ready),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Largest c with c^n <= x, found by plain counting with exact powers.
    function automatic bit pow_le(input longint c, input int n, input longint x);
        longint v = 1;
        for (int i = 0; i < n; i++) begin
            v = v * c;
            if (v > x) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] ref_root(input int x, input int n);
        int r = 0;
        if (n == 0) return 16'hFFFF;
        if (n == 1) return x[15:0];
        while (r < 255 && pow_le(r + 1, n, x)) r++;
        return r[15:0];
    endfunction

    // Cycles ready stays low: each of the 8 bits costs CAND + power steps + detect + CMP.
    function automatic int ref_latency(input int n);
        int lg = 0;
        if (n < 2) return 1;
        while ((n >> (lg + 1)) != 0) lg++;
        return 8 * (lg + $countones(n) + 3);
    endfunction

    int          m_cnt  = 0;
    logic [15:0] m_out  = '0;
    logic [15:0] m_pend = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_cnt <= 0;
            m_out <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  <= ref_latency(int'(inn));
                m_pend <= ref_root(int'(inx), int'(inn));
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_out <= m_pend;
        end
    end

    always @(negedge clk) begin
        check("ready_vs_model", ready, (m_cnt == 0));
        check("out_vs_model", out, m_out);
    end

    task automatic start_job(input logic [15:0] x, input logic [7:0] n);
        @(negedge clk);
        inx   = x;
        inn   = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int low);
        low = 0;
        while (ready !== 1'b1 && low < 160) begin
            low++;
            @(negedge clk);
        end
        if (ready !== 1'b1) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic run_job(input string name, input logic [15:0] x, input logic [7:0] n,
                           input logic [15:0] exp, input int exp_low);
        int low;
        start_job(x, n);
        wait_ready(low);
        check(name, out, exp);
        if (exp_low > 0) check({name, "_busy"}, low, exp_low);
    endtask

    initial begin
        int low;
        logic [15:0] rx;
        logic [7:0]  rn;

        #1 nrst = 1'b0;
        repeat (2) @(negedge clk);
        #2 nrst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_ready", ready, 1'b1);
        check("reset_out", out, 16'd0);

        // Abort mid-job with reset.
        start_job(16'd1000, 8'd3);
        repeat (10) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("midreset_ready", ready, 1'b1);
        check("midreset_out", out, 16'd0);
        @(negedge clk);
        #2 nrst = 1'b1;
        run_job("after_reset", 16'd1000, 8'd3, 16'd10, 0);

        run_job("sqrt_100", 16'd100, 8'd2, 16'd10, 0);
        run_job("sqrt_99", 16'd99, 8'd2, 16'd9, 0);
        run_job("sqrt_65535", 16'd65535, 8'd2, 16'd255, 0);
        run_job("cbrt_1000", 16'd1000, 8'd3, 16'd10, 0);
        run_job("cbrt_999", 16'd999, 8'd3, 16'd9, 0);
        run_job("root16_max", 16'd65535, 8'd16, 16'd1, 0);
        run_job("root255_max", 16'd65535, 8'd255, 16'd1, 0);
        run_job("n1_pass", 16'd12345, 8'd1, 16'd12345, 1);
        run_job("n0_err", 16'd7, 8'd0, 16'hFFFF, 1);
        run_job("x0_n5", 16'd0, 8'd5, 16'd0, 0);

        // start held high with changing inputs while busy must not restart the job.
        @(negedge clk);
        inx   = 16'd32768;
        inn   = 8'd15;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 160 && ready !== 1'b1; i++) begin
            inx = 16'($urandom);
            inn = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("held_ready", ready, 1'b1);
        check("held_out", out, 16'd2);

        // Back-to-back: new start in the first ready cycle; old result holds meanwhile.
        start_job(16'd100, 8'd2);
        wait_ready(low);
        check("b2b_first", out, 16'd10);
        inx   = 16'd99;
        inn   = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", ready, 1'b0);
        check("b2b_hold", out, 16'd10);
        wait_ready(low);
        check("b2b_second", out, 16'd9);

        for (int j = 0; j < 25; j++) begin
            rx = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: rn = 8'($urandom_range(0, 3));
                1: rn = 8'($urandom_range(2, 8));
                2: rn = 8'($urandom_range(9, 20));
                default: rn = 8'($urandom_range(0, 255));
            endcase
            run_job("random", rx, rn, ref_root(int'(rx), int'(rn)), 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
